// File: rtl/s3g_tx.sv
// s3g_tx: S3G transmit framer.
// Sends 0xD5, the length byte, len payload bytes read from a synchronous
// buffer, and a CRC8 over the payload, one byte per UART tx_wr/tx_done
// handshake.
// Optional feature macro: S3G_TX_TIMEOUT_EN. When it is defined, a
// per-byte watchdog aborts the packet after TIMEOUT_CYCLES cycles without
// tx_done.
module s3g_tx #(
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] len,
  output logic       busy,
  output logic       packet_sent,
  output logic       packet_error,
  output logic [7:0] payload_addr,
  input  logic [7:0] payload_data,
  output logic [7:0] tx_data,
  output logic       tx_wr,
  input  logic       tx_done
);

  localparam logic [7:0] SYNC_BYTE = 8'hD5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_LEN,
    S_DATA,
    S_CRC
  } state_t;

  state_t     state_reg, state_next;
  logic       busy_reg, busy_next;
  logic       sent_reg, sent_next;
  logic       err_reg, err_next;
  logic       tx_wr_reg, tx_wr_next;
  logic [7:0] tx_data_reg, tx_data_next;
  logic [7:0] addr_reg, addr_next;
  logic [7:0] crc_reg, crc_next;
  logic [7:0] remaining_reg, remaining_next;

  // Reflected CRC8 (polynomial 0x31, shifted form 0x8C), one byte per call.
  // From crc 0x00, the byte 0x01 produces 0x5E.
  function automatic logic [7:0] next_crc8(input logic [7:0] data, input logic [7:0] crc);
    logic [7:0] c;
    logic [7:0] d;
    c = crc;
    d = data;
    for (int i = 0; i < 8; i++) begin
      if ((c[0] ^ d[0]) == 1'b1) begin
        c = (c >> 1) ^ 8'h8C;
      end else begin
        c = c >> 1;
      end
      d = d >> 1;
    end
    return c;
  endfunction

`ifdef S3G_TX_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] WD_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] wd_cnt_reg, wd_cnt_next;
  logic             wd_expired;

  // Watchdog: cycles elapsed since the last tx_wr. It reads 1 in the cycle
  // after tx_wr, so a value of TIMEOUT_CYCLES-1 means the error pulse lands
  // exactly TIMEOUT_CYCLES cycles after tx_wr.
  always_comb begin
    wd_cnt_next = wd_cnt_reg;
    wd_expired  = 1'b0;
    if (state_reg == S_IDLE) begin
      wd_cnt_next = '0;
    end else if (tx_wr_reg) begin
      wd_cnt_next = CNT_W'(1);
    end else begin
      if (wd_cnt_reg == WD_LIMIT) begin
        wd_expired = ~tx_done;
      end else begin
        wd_cnt_next = wd_cnt_reg + CNT_W'(1);
      end
    end
  end

  // Watchdog counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt_reg <= '0;
    end else begin
      wd_cnt_reg <= wd_cnt_next;
    end
  end
`endif

  // Next-state and output logic. Every output is registered, so each
  // decision appears on the ports one cycle after the input that caused it.
  always_comb begin
    state_next     = state_reg;
    busy_next      = busy_reg;
    sent_next      = 1'b0;
    err_next       = 1'b0;
    tx_wr_next     = 1'b0;
    tx_data_next   = tx_data_reg;
    addr_next      = addr_reg;
    crc_next       = crc_reg;
    remaining_next = remaining_reg;

    case (state_reg)
      S_IDLE: begin
        busy_next = 1'b0;
        // busy_reg is still high in the packet_sent/packet_error cycle,
        // which keeps a new start out until the cycle after that pulse.
        if (start && !busy_reg) begin
          if (len == 8'd0) begin
            err_next = 1'b1;
          end else begin
            remaining_next = len;
            crc_next       = 8'h00;
            addr_next      = 8'h00;
            tx_data_next   = SYNC_BYTE;
            tx_wr_next     = 1'b1;
            busy_next      = 1'b1;
            state_next     = S_HDR;
          end
        end
      end

      S_HDR: begin
        if (tx_done) begin
          // remaining still holds the latched length at this point.
          tx_data_next = remaining_reg;
          tx_wr_next   = 1'b1;
          state_next   = S_LEN;
        end
      end

      S_LEN, S_DATA: begin
        if (tx_done) begin
          tx_wr_next = 1'b1;
          if (remaining_reg != 8'd0) begin
            tx_data_next   = payload_data;
            crc_next       = next_crc8(payload_data, crc_reg);
            addr_next      = addr_reg + 8'd1;
            remaining_next = remaining_reg - 8'd1;
            state_next     = S_DATA;
          end else begin
            tx_data_next = crc_reg;
            state_next   = S_CRC;
          end
        end
      end

      S_CRC: begin
        if (tx_done) begin
          sent_next  = 1'b1;
          state_next = S_IDLE;
        end
      end

      default: begin
        state_next = S_IDLE;
        busy_next  = 1'b0;
      end
    endcase

`ifdef S3G_TX_TIMEOUT_EN
    // Abort overrides the handshake: no further byte goes out.
    if (wd_expired) begin
      err_next   = 1'b1;
      tx_wr_next = 1'b0;
      state_next = S_IDLE;
    end
`endif
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      busy_reg      <= 1'b0;
      sent_reg      <= 1'b0;
      err_reg       <= 1'b0;
      tx_wr_reg     <= 1'b0;
      tx_data_reg   <= 8'h00;
      addr_reg      <= 8'h00;
      crc_reg       <= 8'h00;
      remaining_reg <= 8'h00;
    end else begin
      state_reg     <= state_next;
      busy_reg      <= busy_next;
      sent_reg      <= sent_next;
      err_reg       <= err_next;
      tx_wr_reg     <= tx_wr_next;
      tx_data_reg   <= tx_data_next;
      addr_reg      <= addr_next;
      crc_reg       <= crc_next;
      remaining_reg <= remaining_next;
    end
  end

  assign busy         = busy_reg;
  assign packet_sent  = sent_reg;
  assign packet_error = err_reg;
  assign tx_wr        = tx_wr_reg;
  assign tx_data      = tx_data_reg;
  assign payload_addr = addr_reg;

endmodule

// File: tb/tb_s3g_tx.sv
// tb_s3g_tx: directed bench for s3g_tx with a UART model that returns
// tx_done 10 cycles after each tx_wr and a synchronous payload buffer.
module tb_s3g_tx;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] len;
  logic       busy;
  logic       packet_sent;
  logic       packet_error;
  logic [7:0] payload_addr;
  logic [7:0] payload_data;
  logic [7:0] tx_data;
  logic       tx_wr;
  logic       tx_done;

  logic       uart_done;
  logic       spur_done;
  assign tx_done = uart_done | spur_done;

  int n_checks;
  int n_pass;

  // UART model and monitor state.
  logic [7:0] mem [256];
  logic [7:0] byte_log [1024];
  logic [7:0] addr_log [1024];
  int         wr_cyc [1024];
  int         nbytes;
  int         n_sent;
  int         n_err;
  int         err_cyc;
  int         cyc;
  int         uart_cnt;
  int         hold_from;

  s3g_tx #(.TIMEOUT_CYCLES(50)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .len          (len),
    .busy         (busy),
    .packet_sent  (packet_sent),
    .packet_error (packet_error),
    .payload_addr (payload_addr),
    .payload_data (payload_data),
    .tx_data      (tx_data),
    .tx_wr        (tx_wr),
    .tx_done      (tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous payload buffer: data follows the address by one cycle.
  always @(posedge clk) payload_data <= mem[payload_addr];

  // UART model and monitor, evaluated away from the active edge.
  always @(negedge clk) begin
    cyc = cyc + 1;
    uart_done = 1'b0;
    if (uart_cnt > 0) begin
      uart_cnt = uart_cnt - 1;
      if (uart_cnt == 0) uart_done = 1'b1;
    end
    if (tx_wr) begin
      byte_log[nbytes] = tx_data;
      addr_log[nbytes] = payload_addr;
      wr_cyc[nbytes]   = cyc;
      if (nbytes < hold_from) uart_cnt = 10;
      nbytes = nbytes + 1;
    end
    if (packet_sent) n_sent = n_sent + 1;
    if (packet_error) begin
      n_err   = n_err + 1;
      err_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (act === exp) begin
      n_pass = n_pass + 1;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic start_pkt(input logic [7:0] n);
    @(posedge clk);
    #2 start = 1'b1;
    len = n;
    @(posedge clk);
    #2 start = 1'b0;
  endtask

  // Wait for packet_sent or packet_error; optionally re-assert start while
  // the packet is in flight.
  task automatic wait_end(input bit noise, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      #1;
      start = (noise && i >= 3 && i < 30) ? 1'b1 : 1'b0;
      if (packet_sent || packet_error) begin
        seen = 1'b1;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic check_frame(input string tag, input int base, input int n, input logic [7:0] exp [8]);
    check({tag, "_count"}, nbytes - base, n);
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_byte%0d", tag, i), byte_log[base + i], exp[i]);
    end
  endtask

  initial begin
    logic [7:0] exp [8];
    bit         seen;
    int         base;
    int         sent0;
    int         err0;

    n_checks = 0; n_pass = 0;
    nbytes = 0; n_sent = 0; n_err = 0; err_cyc = 0; cyc = 0;
    uart_cnt = 0; hold_from = 1 << 30;
    uart_done = 1'b0; spur_done = 1'b0;
    start = 1'b0; len = 8'd0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;

    // Reset values.
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_tx_wr", tx_wr, 0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_addr", payload_addr, 8'h00);
    check("rst_sent_err", {packet_sent, packet_error}, 0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // len=1, payload 0x01 -> D5 01 01 5E.
    mem[0] = 8'h01;
    base = nbytes;
    sent0 = n_sent;
    start_pkt(8'd1);
    @(negedge clk);
    #1;
    check("t1_wr_latency", tx_wr, 1);
    check("t1_first_byte", tx_data, 8'hD5);
    check("t1_busy", busy, 1);
    wait_end(1'b0, seen);
    check("t1_done_seen", seen, 1);
    check("t1_sent_pulse", packet_sent, 1);
    check("t1_busy_in_sent", busy, 1);
    @(negedge clk);
    #1;
    check("t1_busy_after", busy, 0);
    check("t1_sent_one_cycle", packet_sent, 0);
    check("t1_sent_count", n_sent - sent0, 1);
    exp = '{8'hD5, 8'h01, 8'h01, 8'h5E, 0, 0, 0, 0};
    check_frame("t1", base, 4, exp);

    // len=3 zeros -> D5 03 00 00 00 00, addresses 0,1,2,3.
    mem[0] = 8'h00; mem[1] = 8'h00; mem[2] = 8'h00;
    base = nbytes;
    start_pkt(8'd3);
    wait_end(1'b0, seen);
    check("t2_done_seen", seen, 1);
    @(negedge clk);
    #1;
    exp = '{8'hD5, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0};
    check_frame("t2", base, 6, exp);
    check("t2_addr_hdr", addr_log[base], 0);
    check("t2_addr_p0", addr_log[base + 2], 1);
    check("t2_addr_p1", addr_log[base + 3], 2);
    check("t2_addr_p2", addr_log[base + 4], 3);
    check("t2_addr_end", payload_addr, 3);

    // len=0 -> single packet_error, no bytes, busy stays low.
    base = nbytes;
    err0 = n_err;
    start_pkt(8'd0);
    @(negedge clk);
    #1;
    check("t3_err_pulse", packet_error, 1);
    check("t3_busy", busy, 0);
    check("t3_no_wr", tx_wr, 0);
    repeat (15) @(negedge clk);
    #1;
    check("t3_err_count", n_err - err0, 1);
    check("t3_no_bytes", nbytes - base, 0);

    // Spurious tx_done in idle, then len=2 {01,02} with start re-asserted
    // mid-packet -> D5 02 01 02 78.
    base = nbytes;
    @(negedge clk);
    spur_done = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    check("t4_spur_no_bytes", nbytes - base, 0);
    check("t4_spur_busy", busy, 0);
    mem[0] = 8'h01; mem[1] = 8'h02;
    sent0 = n_sent;
    start_pkt(8'd2);
    wait_end(1'b1, seen);
    check("t4_done_seen", seen, 1);
    repeat (20) @(negedge clk);
    #1;
    exp = '{8'hD5, 8'h02, 8'h01, 8'h02, 8'h78, 0, 0, 0};
    check_frame("t4", base, 5, exp);
    check("t4_sent_count", n_sent - sent0, 1);
    check("t4_busy_after", busy, 0);

    // Reset in the middle of a len=255 payload, then len=2 {00,01}.
    for (int i = 0; i < 256; i++) mem[i] = 8'(i + 3);
    base = nbytes;
    start_pkt(8'd255);
    seen = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      #1;
      if (nbytes - base >= 8) begin
        seen = 1'b1;
        break;
      end
    end
    check("t5_progress", seen, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_busy", busy, 0);
    check("t5_rst_tx_wr", tx_wr, 0);
    check("t5_rst_tx_data", tx_data, 8'h00);
    check("t5_rst_addr", payload_addr, 8'h00);
    check("t5_rst_sent_err", {packet_sent, packet_error}, 0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    base = nbytes;
    repeat (20) @(negedge clk);
    #1;
    check("t5_inflight_ignored", nbytes - base, 0);
    check("t5_idle_busy", busy, 0);
    mem[0] = 8'h00; mem[1] = 8'h01;
    start_pkt(8'd2);
    wait_end(1'b0, seen);
    check("t5_done_seen", seen, 1);
    @(negedge clk);
    #1;
    exp = '{8'hD5, 8'h02, 8'h00, 8'h01, 8'h5E, 0, 0, 0};
    check_frame("t5", base, 5, exp);

    // UART withholds tx_done of the length byte.
    base = nbytes;
    err0 = n_err;
    hold_from = base + 1;
    start_pkt(8'd4);
`ifdef S3G_TX_TIMEOUT_EN
    wait_end(1'b0, seen);
    check("t6_err_seen", seen, 1);
    check("t6_err_pulse", packet_error, 1);
    check("t6_err_delay", err_cyc - wr_cyc[base + 1], 50);
    @(negedge clk);
    #1;
    check("t6_busy_after", busy, 0);
    repeat (30) @(negedge clk);
    #1;
    check("t6_err_count", n_err - err0, 1);
    check("t6_bytes", nbytes - base, 2);
`else
    repeat (200) @(negedge clk);
    #1;
    check("t6_busy_held", busy, 1);
    check("t6_no_err", n_err - err0, 0);
    check("t6_bytes", nbytes - base, 2);
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("t6_recover_busy", busy, 0);
`endif
    hold_from = 1 << 30;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
